sp_sync_ctrl: RTL
=================

SP_SYNC_CTRL -- requirements
Module: sp_sync_ctrl

Interface
REQ-001 Parameter COMMA, default 8'hBC, is the comma/idle symbol.
REQ-002 Parameter BC_NEEDED, default 4, is the number of consecutive commas needed to acquire sync (range 1..7).
REQ-003 Parameter GAP_MAX, default 64, is the maximum cycles allowed between commas while synchronized (range 2..255).
REQ-004 clk_4f  input  1  byte clock; all logic on its rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  8  byte from the serial-to-parallel deserializer.
REQ-007 valid_in  input  1  data_in holds a new byte this cycle.
REQ-008 data_out  output  8  forwarded payload byte.
REQ-009 valid_out  output  1  data_out holds a payload byte.
REQ-010 active  output  1  link synchronized; high in SYNC and ACTIVE.
REQ-011 sync_lost  output  1  one-cycle pulse when sync is lost.

Function
REQ-012 FSM states: SEARCH, SYNC, ACTIVE; a 3-bit comma counter and an 8-bit gap counter.
REQ-013 SEARCH: each valid_in byte == COMMA increments the comma counter; any other valid byte clears it; cycles with valid_in=0 leave it unchanged.
REQ-014 SEARCH -> SYNC on the valid comma that brings the counter to BC_NEEDED; the counter then clears.
REQ-015 SYNC: a valid comma stays in SYNC; the first valid non-comma byte moves to ACTIVE and is forwarded.
REQ-016 SYNC/ACTIVE: a valid byte != COMMA is forwarded: data_out = data_in and valid_out = 1 on the following cycle (1-cycle latency).
REQ-017 valid_out = 0 in every other cycle; data_out holds its last value when valid_out = 0.
REQ-018 Commas are never forwarded.
REQ-019 Gap counter: cleared on every valid comma and on entry to SYNC; otherwise increments each cycle in SYNC/ACTIVE and saturates at 255.
REQ-020 When the gap counter reaches GAP_MAX, the FSM goes to SEARCH, sync_lost pulses for 1 cycle, and the comma and gap counters clear.
REQ-021 A valid non-comma byte arriving in the same cycle as the timeout is dropped.
REQ-022 A valid comma arriving in the same cycle as the timeout wins: the gap counter clears and the FSM stays synchronized.
REQ-023 An ACTIVE byte accepted before the timeout cycle still appears on data_out one cycle later.
REQ-024 active is registered: high the cycle after entering SYNC, low the cycle after leaving ACTIVE/SYNC.

Reset
REQ-025 reset_L low clears immediately and asynchronously: state = SEARCH, both counters = 0, data_out = 8'h00, valid_out = 0, active = 0, sync_lost = 0, stats counter = 0.
REQ-026 Reset asserted mid-packet discards in-flight bytes, with no sync_lost pulse.
REQ-027 Release is synchronous to clk_4f; the first valid byte is evaluated on the first rising edge after release.

Configuration
REQ-028 With macro SP_SYNC_STATS_EN defined, add output loss_count (8 bits): it increments on each sync_lost pulse, saturates at 8'hFF, and is cleared by reset.
REQ-029 Without SP_SYNC_STATS_EN, the loss_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-030 Acquire: reset release, then 4 valid 8'hBC bytes -> active = 1 the cycle after the 4th; valid_out stays 0.
REQ-031 Broken search: BC, BC, 8'h55, BC, BC, BC -> active stays 0; a 4th consecutive BC then sets active.
REQ-032 Forwarding: after sync, send 8'h11, 8'hBC, 8'h22 -> valid_out pulses with data_out 8'h11, then 8'h22, each 1 cycle after input; no output for BC.
REQ-033 Timeout: after sync, 64 cycles of non-comma bytes -> sync_lost pulses once, active falls, and a new 4-BC sequence re-acquires; with SP_SYNC_STATS_EN, loss_count = 1.
REQ-034 Race: a comma in exactly the GAP_MAX cycle -> no sync_lost and active stays 1.
REQ-035 Reset mid-ACTIVE: pull reset_L low between edges -> valid_out, active and data_out clear without waiting for a clock edge.

Source files
------------

// File: rtl/sp_sync_ctrl.sv
// ============================================================================
// sp_sync_ctrl : comma-based byte-sync acquisition, payload forwarding, gap timeout
// Optional loss counter port enabled by macro SP_SYNC_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module sp_sync_ctrl #(
  parameter logic [7:0]  COMMA     = 8'hBC,
  parameter int unsigned BC_NEEDED = 4,
  parameter int unsigned GAP_MAX   = 64
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       sync_lost
`ifdef SP_SYNC_STATS_EN
  ,
  output logic [7:0] loss_count
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [2:0] BC_LAST  = 3'(BC_NEEDED - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_out_q, valid_out_d;
  logic       active_q, active_d;
  logic       sync_lost_q, sync_lost_d;
  logic       is_comma, is_data;

  assign is_comma = valid_in && (data_in == COMMA);
  assign is_data  = valid_in && (data_in != COMMA);

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    gap_d       = gap_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    sync_lost_d = 1'b0;

    case (state_q)
      SEARCH: begin
        gap_d = 8'd0;
        if (is_comma) begin
          if (comma_cnt_q == BC_LAST) begin
            state_d     = SYNC;
            comma_cnt_d = 3'd0;
          end else begin
            comma_cnt_d = comma_cnt_q + 3'd1;
          end
        end else if (is_data) begin
          comma_cnt_d = 3'd0;
        end
      end
      default: begin
        // A comma landing in the timeout cycle rescues the link.
        if (is_comma) begin
          gap_d = 8'd0;
        end else if (gap_q == GAP_LAST) begin
          state_d     = SEARCH;
          sync_lost_d = 1'b1;
          comma_cnt_d = 3'd0;
          gap_d       = 8'd0;
        end else begin
          gap_d = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
          if (is_data) begin
            data_out_d  = data_in;
            valid_out_d = 1'b1;
            state_d     = ACTIVE;
          end
        end
      end
    endcase

    active_d = (state_d != SEARCH);
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= SEARCH;
      comma_cnt_q <= 3'd0;
      gap_q       <= 8'd0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      active_q    <= 1'b0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      gap_q       <= gap_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      active_q    <= active_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign active    = active_q;
  assign sync_lost = sync_lost_q;

`ifdef SP_SYNC_STATS_EN
  logic [7:0] loss_count_q, loss_count_d;

  always_comb begin
    loss_count_d = loss_count_q;
    if (sync_lost_d && (loss_count_q != 8'hFF)) begin
      loss_count_d = loss_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      loss_count_q <= 8'h00;
    end else begin
      loss_count_q <= loss_count_d;
    end
  end

  assign loss_count = loss_count_q;
`endif

endmodule

`default_nettype wire
